// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: synchroniser, glitch filter, mode select,
// event pulse, sticky flag and saturating counter per channel.
module edge_detector_multi #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_W         = 8,
  parameter bit INIT_LEVEL    = 1'b0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       in,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       sticky,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic                      irq
);

  localparam int FW =
    (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl_q, lvl_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic                   pulse_q, pulse_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      lvl_d   = lvl_q;
      fcnt_d  = fcnt_q;
      pulse_d = 1'b0;
      if (s == lvl_q) begin
        fcnt_d = '0;
      end else if (fcnt_q == FMAX) begin
        lvl_d   = s;
        fcnt_d  = '0;
        pulse_d = s ? mode[2*i] : mode[2*i+1];
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // Flag and counter follow the visible pulse, so a clear
    // issued during the pulse cycle collides with it.
    always_comb begin
      sticky_d = pulse_q | (sticky_q & ~clear[i]);
      cnt_d    = cnt_q;
      if (clear[i])
        cnt_d = pulse_q ? CONE : '0;
      else if (pulse_q && cnt_q != CMAX)
        cnt_d = cnt_q + CONE;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_q   <= {SYNC_STAGES{INIT_LEVEL}};
        lvl_q    <= INIT_LEVEL;
        fcnt_q   <= '0;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], in[i]};
        lvl_q    <= lvl_d;
        fcnt_q   <= fcnt_d;
        pulse_q  <= pulse_d;
        sticky_q <= sticky_d;
        cnt_q    <= cnt_d;
      end
    end

    assign level[i]                   = lvl_q;
    assign pulse[i]                   = pulse_q;
    assign sticky[i]                  = sticky_q;
    assign count[CNT_W*i +: CNT_W]    = cnt_q;
  end

  assign irq = |sticky;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi (4 channels, 2-bit counters).
module tb_edge_detector_multi;

  logic       clk;
  logic       resetn;
  logic [3:0] in;
  logic [7:0] mode;
  logic [3:0] clear;
  logic [3:0] level;
  logic [3:0] pulse;
  logic [3:0] sticky;
  logic [7:0] count;
  logic       irq;

  int checks;
  int errors;

  edge_detector_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(3),
    .CNT_W(2), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .resetn(resetn), .in(in), .mode(mode),
    .clear(clear), .level(level), .pulse(pulse),
    .sticky(sticky), .count(count), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n, input int ch, output int np);
    np = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (pulse[ch]) np++;
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    resetn = 1'b0;
    in     = v;
    clear  = 4'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  int np;

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    in     = 4'b1111;
    mode   = 8'b00000001;
    clear  = 4'b0;
    tick();
    tick();
    check("rst_level", 32'(level), 32'h0);
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_sticky", 32'(sticky), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    resetn = 1'b1;
    wait_n(5, 0, np);
    check("lat_nopulse", 32'(np), 32'h0);
    check("lat_level5", 32'(level), 32'h0);
    tick();
    check("lat_level6", 32'(level), 32'hf);
    check("lat_pulse6", 32'(pulse), 32'h1);
    clear = 4'b0001;
    tick();
    check("coll_sticky", 32'(sticky), 32'h1);
    check("coll_count", 32'(count), 32'h1);
    check("coll_pulse", 32'(pulse), 32'h0);
    tick();
    check("clr_sticky", 32'(sticky), 32'h0);
    check("clr_count", 32'(count), 32'h0);
    check("clr_irq", 32'(irq), 32'h0);
    clear = 4'b0;

    // glitch rejection on ch1
    do_reset(4'b0);
    mode = 8'b00000100;
    in[1] = 1'b1;
    tick(); tick(); tick();
    in[1] = 1'b0;
    wait_n(10, 1, np);
    check("gl_np", 32'(np), 32'h0);
    check("gl_level", 32'(level[1]), 32'h0);
    check("gl_sticky", 32'(sticky[1]), 32'h0);
    in[1] = 1'b1;
    wait_n(4, 1, np);
    in[1] = 1'b0;
    tick();
    check("acc_early", 32'(np + pulse[1]), 32'h0);
    tick();
    check("acc_level", 32'(level[1]), 32'h1);
    check("acc_pulse", 32'(pulse[1]), 32'h1);
    tick();
    check("acc_sticky", 32'(sticky[1]), 32'h1);
    check("acc_irq", 32'(irq), 32'h1);
    wait_n(10, 1, np);
    check("acc_fall_np", 32'(np), 32'h0);
    check("acc_fall_lvl", 32'(level[1]), 32'h0);

    // modes on ch2
    do_reset(4'b0);
    mode = 8'b00110000;
    in[2] = 1'b1;
    wait_n(8, 2, np);
    check("m11_rise", 32'(np), 32'h1);
    in[2] = 1'b0;
    wait_n(8, 2, np);
    check("m11_fall", 32'(np), 32'h1);
    check("m11_count", 32'(count[5:4]), 32'h2);
    clear = 4'b0100;
    tick();
    clear = 4'b0;
    check("m_clr", 32'(count[5:4]), 32'h0);
    mode = 8'b00100000;
    in[2] = 1'b1;
    wait_n(8, 2, np);
    check("m10_rise", 32'(np), 32'h0);
    in[2] = 1'b0;
    wait_n(8, 2, np);
    check("m10_fall", 32'(np), 32'h1);
    check("m10_count", 32'(count[5:4]), 32'h1);
    mode = 8'b00000000;
    in[2] = 1'b1;
    wait_n(8, 2, np);
    check("m00_np", 32'(np), 32'h0);
    check("m00_level", 32'(level[2]), 32'h1);
    check("m00_count", 32'(count[5:4]), 32'h1);

    // saturation on ch3
    do_reset(4'b0);
    mode = 8'b01000000;
    for (int e = 0; e < 5; e++) begin
      in[3] = 1'b1;
      wait_n(8, 3, np);
      check("sat_np", 32'(np), 32'h1);
      check("sat_cnt", 32'(count[7:6]),
            (e < 3) ? 32'(e + 1) : 32'h3);
      in[3] = 1'b0;
      wait_n(8, 3, np);
    end
    check("sat_sticky", 32'(sticky[3]), 32'h1);
    check("sat_irq", 32'(irq), 32'h1);

    // reset mid-filter on ch0
    do_reset(4'b0);
    mode = 8'b00000001;
    in[0] = 1'b1;
    tick(); tick();
    resetn = 1'b0;
    #1;
    check("mid_rst_lvl", 32'(level), 32'h0);
    tick();
    check("mid_rst_pulse", 32'(pulse), 32'h0);
    resetn = 1'b1;
    wait_n(5, 0, np);
    check("mid_np", 32'(np), 32'h0);
    check("mid_lvl5", 32'(level[0]), 32'h0);
    tick();
    check("mid_lvl6", 32'(level[0]), 32'h1);
    check("mid_pulse6", 32'(pulse[0]), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
